rs_age_ordered: RTL and testbench

Parametrised reservation station for the out-of-order core, sitting between decode/rename dispatch and the ALU. It holds up to DEPTH renamed instructions and snoops CDB_N result-broadcast channels for operand wakeup. It issues the oldest ready entry through a registered valid/ready port that tolerates ALU back-pressure. Relative to the previous single-bus station, it adds:
- a configurable number of wakeup channels;
- same-cycle dispatch bypass;
- age ordering;
- an occupancy count with an almost-full flag.

---
 rtl/rs_age_ordered_pkg.sv | 19 +
 rtl/rs_age_ordered_if.sv | 57 +++++
 rtl/rs_age_ordered_picker.sv | 30 +++
 rtl/rs_age_ordered.sv | 233 +++++++++++++++++++++++
 tb/tb_rs_age_ordered.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_age_ordered_pkg.sv
// rs_age_ordered_pkg
//   Constants shared by the reservation station, its interface and the bench.
//   Holds the operation-field widths, the default datapath widths, and the
//   packed operation-field struct that every entry and the issue register carry.
package rs_age_ordered_pkg;

  localparam int OPCODE_W       = 7;
  localparam int FUNC3_W        = 3;
  localparam int DATA_W_DEFAULT = 32;
  localparam int ROB_W_DEFAULT  = 4;

  // Operation fields travel together from dispatch to issue untouched.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC3_W-1:0]  func3;
    logic                func1;
  } op_t;

endpackage

// File: rtl/rs_age_ordered_if.sv
// rs_age_ordered_if
//   Bundles the dispatch port, the CDB snoop channels, the issue port and the
//   occupancy status of the reservation station.
//   master : dispatch/rename side plus ALU (drives inst_*, cdb_*, exe_ready)
//   slave  : the reservation station (drives exe_*, rs_*)
interface rs_age_ordered_if
  import rs_age_ordered_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CDB_N  = 2,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ROB_W  = ROB_W_DEFAULT
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                    inst_valid;
  logic [OPCODE_W-1:0]     inst_opcode;
  logic [FUNC3_W-1:0]      inst_func3;
  logic                    inst_func1;
  logic                    inst_rs1_valid, inst_rs2_valid;
  logic [DATA_W-1:0]       inst_rs1_data, inst_rs2_data;
  logic [ROB_W-1:0]        inst_rs1_rob, inst_rs2_rob, inst_rd_rob;
  logic [DATA_W-1:0]       inst_imm, inst_pc;

  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*ROB_W-1:0]  cdb_rob;
  logic [CDB_N*DATA_W-1:0] cdb_data;

  logic                    exe_valid, exe_ready;
  logic [OPCODE_W-1:0]     exe_opcode;
  logic [FUNC3_W-1:0]      exe_func3;
  logic                    exe_func1;
  logic [DATA_W-1:0]       exe_data1, exe_data2, exe_imm, exe_pc;
  logic [ROB_W-1:0]        exe_rob;

  logic                    rs_full, rs_almost_full;
  logic [CNT_W-1:0]        rs_count;

  modport master (
    output inst_valid, inst_opcode, inst_func3, inst_func1,
           inst_rs1_valid, inst_rs2_valid, inst_rs1_data, inst_rs2_data,
           inst_rs1_rob, inst_rs2_rob, inst_rd_rob, inst_imm, inst_pc,
           cdb_valid, cdb_rob, cdb_data, exe_ready,
    input  exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
           exe_imm, exe_pc, exe_rob, rs_full, rs_almost_full, rs_count
  );

  modport slave (
    input  inst_valid, inst_opcode, inst_func3, inst_func1,
           inst_rs1_valid, inst_rs2_valid, inst_rs1_data, inst_rs2_data,
           inst_rs1_rob, inst_rs2_rob, inst_rd_rob, inst_imm, inst_pc,
           cdb_valid, cdb_rob, cdb_data, exe_ready,
    output exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
           exe_imm, exe_pc, exe_rob, rs_full, rs_almost_full, rs_count
  );

endinterface

// File: rtl/rs_age_ordered_picker.sv
// rs_age_picker
//   Combinational oldest-ready selector, shared with the load/store buffer.
//   ready_i : candidate vector
//   older_i : older_i[j][i] = 1 when entry j is older than entry i; the
//             diagonal must be zero
//   grant_o : one-hot grant of the ready entry no other ready entry is older than
//   found_o : at least one candidate is ready
module rs_age_picker #(
  parameter int N = 16
) (
  input  logic [N-1:0]        ready_i,
  input  logic [N-1:0][N-1:0] older_i,
  output logic [N-1:0]        grant_o,
  output logic                found_o
);

  // An entry wins when it is ready and no other ready entry is older. The
  // zero diagonal lets the inner loop skip the j == i exclusion.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = ready_i[i];
      for (int j = 0; j < N; j++) begin
        if (ready_i[j] && older_i[j][i]) grant_o[i] = 1'b0;
      end
    end
    found_o = |ready_i;
  end

endmodule

// File: rtl/rs_age_ordered.sv
// rs_age_ordered
//   Age-ordered reservation station between dispatch and the ALU.
//   clk, rst_n : clock, asynchronous active-low reset
//   rdy        : global enable, low freezes all state
//   rollback   : flushes entries, count and the issue register
//   bus        : dispatch, CDB snoop, issue handshake and occupancy (slave side)
module rs_age_ordered
  import rs_age_ordered_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CDB_N  = 2,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ROB_W  = ROB_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy,
  input  logic            rollback,
  rs_age_ordered_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [DEPTH-1:0]            v1_q, v1_d, v2_q, v2_d;
  logic [DATA_W-1:0]           d1_q [DEPTH];
  logic [DATA_W-1:0]           d1_d [DEPTH];
  logic [DATA_W-1:0]           d2_q [DEPTH];
  logic [DATA_W-1:0]           d2_d [DEPTH];
  logic [ROB_W-1:0]            t1_q [DEPTH];
  logic [ROB_W-1:0]            t2_q [DEPTH];
  logic [ROB_W-1:0]            rd_q [DEPTH];
  logic [DATA_W-1:0]           imm_q [DEPTH];
  logic [DATA_W-1:0]           pc_q [DEPTH];
  op_t                         op_q [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] older_q;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              exeValid_q;
  op_t               exeOp_q;
  logic [DATA_W-1:0] exeData1_q, exeData2_q, exeImm_q, exePc_q;
  logic [ROB_W-1:0]  exeRob_q;

  logic [ROB_W-1:0]  cdbTag [CDB_N];
  logic [DATA_W-1:0] cdbData [CDB_N];
  logic              full, allocFound, dispatch, issueFire, issueTake, pickFound;
  logic [IDX_W-1:0]  allocIdx, selIdx;
  logic [DEPTH-1:0]  readyVec, grant;
  logic              byp1Hit, byp2Hit;
  logic [DATA_W-1:0] byp1Data, byp2Data;

  always_comb begin
    for (int k = 0; k < CDB_N; k++) begin
      cdbTag[k]  = bus.cdb_rob[k*ROB_W +: ROB_W];
      cdbData[k] = bus.cdb_data[k*DATA_W +: DATA_W];
    end
  end

  // Lowest-index free slot, from registered busy bits only, so a slot freed
  // by this edge's issue becomes allocatable one cycle later.
  always_comb begin
    allocFound = 1'b0;
    allocIdx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        allocFound = 1'b1;
        allocIdx   = IDX_W'(i);
      end
    end
  end

  assign full      = (count_q == CNT_W'(DEPTH));
  assign dispatch  = rdy && !rollback && bus.inst_valid && !full && allocFound;
  assign readyVec  = busy_q & v1_q & v2_q;
  assign issueFire = rdy && !rollback && (!exeValid_q || bus.exe_ready);
  assign issueTake = issueFire && pickFound;

  rs_age_picker #(.N(DEPTH)) u_picker (
    .ready_i (readyVec),
    .older_i (older_q),
    .grant_o (grant),
    .found_o (pickFound)
  );

  always_comb begin
    selIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) selIdx = IDX_W'(i);
    end
  end

  // Bypass for operands arriving with dispatch; the descending scan leaves
  // the lowest matching channel as the winner.
  always_comb begin
    byp1Hit  = 1'b0;
    byp2Hit  = 1'b0;
    byp1Data = '0;
    byp2Data = '0;
    for (int k = CDB_N-1; k >= 0; k--) begin
      if (bus.cdb_valid[k] && cdbTag[k] == bus.inst_rs1_rob) begin
        byp1Hit  = 1'b1;
        byp1Data = cdbData[k];
      end
      if (bus.cdb_valid[k] && cdbTag[k] == bus.inst_rs2_rob) begin
        byp2Hit  = 1'b1;
        byp2Data = cdbData[k];
      end
    end
  end

  // Next state of busy/operand fields: CAM wakeup on waiting operands, busy
  // clear for the issued entry, then the dispatch write into the free slot.
  always_comb begin
    busy_d = busy_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = CDB_N-1; k >= 0; k--) begin
        if (busy_q[i] && bus.cdb_valid[k]) begin
          if (!v1_q[i] && cdbTag[k] == t1_q[i]) begin
            v1_d[i] = 1'b1;
            d1_d[i] = cdbData[k];
          end
          if (!v2_q[i] && cdbTag[k] == t2_q[i]) begin
            v2_d[i] = 1'b1;
            d2_d[i] = cdbData[k];
          end
        end
      end
    end
    if (issueTake) busy_d[selIdx] = 1'b0;
    if (dispatch) begin
      busy_d[allocIdx] = 1'b1;
      v1_d[allocIdx]   = bus.inst_rs1_valid || byp1Hit;
      v2_d[allocIdx]   = bus.inst_rs2_valid || byp2Hit;
      d1_d[allocIdx]   = bus.inst_rs1_valid ? bus.inst_rs1_data : byp1Data;
      d2_d[allocIdx]   = bus.inst_rs2_valid ? bus.inst_rs2_data : byp2Data;
    end
  end

  // Entry storage and age matrix. A new entry's row is cleared (older than
  // nobody) and its column copies the busy vector (younger than all live
  // entries); stale rows of freed slots are masked by the ready vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      older_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d1_q[i]  <= '0;
        d2_q[i]  <= '0;
        t1_q[i]  <= '0;
        t2_q[i]  <= '0;
        rd_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        op_q[i]  <= '0;
      end
    end else if (rollback) begin
      busy_q <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      if (dispatch) begin
        op_q[allocIdx]  <= '{opcode: bus.inst_opcode, func3: bus.inst_func3,
                             func1: bus.inst_func1};
        t1_q[allocIdx]  <= bus.inst_rs1_rob;
        t2_q[allocIdx]  <= bus.inst_rs2_rob;
        rd_q[allocIdx]  <= bus.inst_rd_rob;
        imm_q[allocIdx] <= bus.inst_imm;
        pc_q[allocIdx]  <= bus.inst_pc;
        for (int j = 0; j < DEPTH; j++) begin
          older_q[j][allocIdx] <= busy_q[j];
          older_q[allocIdx][j] <= 1'b0;
        end
      end
    end
  end

  // Issue register: reloads only when empty or being consumed, so the
  // payload is frozen under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exeValid_q <= 1'b0;
      exeOp_q    <= '0;
      exeData1_q <= '0;
      exeData2_q <= '0;
      exeImm_q   <= '0;
      exePc_q    <= '0;
      exeRob_q   <= '0;
    end else if (rollback) begin
      exeValid_q <= 1'b0;
    end else if (issueFire) begin
      exeValid_q <= pickFound;
      if (pickFound) begin
        exeOp_q    <= op_q[selIdx];
        exeData1_q <= d1_q[selIdx];
        exeData2_q <= d2_q[selIdx];
        exeImm_q   <= imm_q[selIdx];
        exePc_q    <= pc_q[selIdx];
        exeRob_q   <= rd_q[selIdx];
      end
    end
  end

  assign count_d = count_q + CNT_W'(dispatch) - CNT_W'(issueTake);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_q <= '0;
    else if (rollback) count_q <= '0;
    else if (rdy)      count_q <= count_d;
  end

  assign bus.exe_valid      = exeValid_q;
  assign bus.exe_opcode     = exeOp_q.opcode;
  assign bus.exe_func3      = exeOp_q.func3;
  assign bus.exe_func1      = exeOp_q.func1;
  assign bus.exe_data1      = exeData1_q;
  assign bus.exe_data2      = exeData2_q;
  assign bus.exe_imm        = exeImm_q;
  assign bus.exe_pc         = exePc_q;
  assign bus.exe_rob        = exeRob_q;
  assign bus.rs_count       = count_q;
  assign bus.rs_full        = full;
  assign bus.rs_almost_full = (count_q >= CNT_W'(DEPTH-1));

endmodule

// File: tb/tb_rs_age_ordered.sv
// tb_rs_age_ordered
//   Drives directed and random traffic into rs_age_ordered. A queue-based
//   model (list in dispatch order = age order) predicts each issued payload
//   into a scoreboard; a negedge monitor compares the DUT against it.
module tb_rs_age_ordered;
  import rs_age_ordered_pkg::*;

  localparam int DEPTH  = 16;
  localparam int CDB_N  = 2;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic rollback = 1'b0;

  rs_age_ordered_if #(.DEPTH(DEPTH), .CDB_N(CDB_N), .DATA_W(DATA_W), .ROB_W(ROB_W)) bus ();

  rs_age_ordered #(.DEPTH(DEPTH), .CDB_N(CDB_N), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func1;
    logic        v1, v2;
    logic [31:0] d1, d2;
    logic [3:0]  t1, t2, rd;
    logic [31:0] imm, pc;
  } mEntry_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func1;
    logic [31:0] data1, data2, imm, pc;
    logic [3:0]  rob;
  } payload_t;

  mEntry_t  pend[$];
  payload_t sb[$];
  bit       mExeValid = 1'b0;
  int       checks = 0;
  int       errors = 0;

  task automatic checkOutput(input string name, input logic [159:0] actual,
                             input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit cdbHit(input logic [3:0] tag, output logic [31:0] data);
    data = '0;
    for (int k = 0; k < CDB_N; k++) begin
      if (bus.cdb_valid[k] && bus.cdb_rob[k*ROB_W +: ROB_W] == tag) begin
        data = bus.cdb_data[k*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Reference model: oldest ready entry in the list issues when the output
  // register is free; waiting operands then capture broadcasts; a dispatch
  // (if the station was not full before the edge) joins the tail.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      sb.delete();
      mExeValid = 1'b0;
    end else if (rollback) begin
      pend.delete();
      sb.delete();
      mExeValid = 1'b0;
    end else if (rdy) begin : step
      int       preCount;
      int       pick;
      logic [31:0] w;
      mEntry_t  e;
      payload_t p;
      preCount = pend.size();
      if (!mExeValid || bus.exe_ready) begin
        pick = -1;
        foreach (pend[i]) if (pick < 0 && pend[i].v1 && pend[i].v2) pick = i;
        if (pick >= 0) begin
          e = pend[pick];
          p = '{opcode: e.opcode, func3: e.func3, func1: e.func1, data1: e.d1,
                data2: e.d2, imm: e.imm, pc: e.pc, rob: e.rd};
          sb.push_back(p);
          pend.delete(pick);
          mExeValid = 1'b1;
        end else begin
          mExeValid = 1'b0;
        end
      end
      foreach (pend[i]) begin
        e = pend[i];
        if (!e.v1 && cdbHit(e.t1, w)) begin e.v1 = 1'b1; e.d1 = w; end
        if (!e.v2 && cdbHit(e.t2, w)) begin e.v2 = 1'b1; e.d2 = w; end
        pend[i] = e;
      end
      if (bus.inst_valid && preCount < DEPTH) begin
        e.opcode = bus.inst_opcode;   e.func3 = bus.inst_func3; e.func1 = bus.inst_func1;
        e.v1 = bus.inst_rs1_valid;    e.d1 = bus.inst_rs1_data; e.t1 = bus.inst_rs1_rob;
        e.v2 = bus.inst_rs2_valid;    e.d2 = bus.inst_rs2_data; e.t2 = bus.inst_rs2_rob;
        e.rd = bus.inst_rd_rob;       e.imm = bus.inst_imm;     e.pc = bus.inst_pc;
        if (!e.v1 && cdbHit(e.t1, w)) begin e.v1 = 1'b1; e.d1 = w; end
        if (!e.v2 && cdbHit(e.t2, w)) begin e.v2 = 1'b1; e.d2 = w; end
        pend.push_back(e);
      end
    end
  end

  // Monitor: status every cycle, payload against the scoreboard head whenever
  // exe_valid is high, pop when the ALU actually consumes it.
  always @(negedge clk) begin
    if (rst_n) begin
      payload_t act;
      checkOutput("exe_valid", 160'(bus.exe_valid), 160'(mExeValid));
      checkOutput("rs_count", 160'(bus.rs_count), 160'(pend.size()));
      checkOutput("rs_full", 160'(bus.rs_full), 160'(pend.size() == DEPTH));
      checkOutput("rs_almost_full", 160'(bus.rs_almost_full), 160'(pend.size() >= DEPTH-1));
      if (bus.exe_valid) begin
        act = '{opcode: bus.exe_opcode, func3: bus.exe_func3, func1: bus.exe_func1,
                data1: bus.exe_data1, data2: bus.exe_data2, imm: bus.exe_imm,
                pc: bus.exe_pc, rob: bus.exe_rob};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_issue: got %0h expected none at %0t", act, $time);
        end else begin
          checkOutput("payload", 160'(act), 160'(sb[0]));
          if (bus.exe_ready && rdy && !rollback) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic setDispatch(input logic v1, input logic [31:0] d1, input logic [3:0] t1,
                             input logic v2, input logic [31:0] d2, input logic [3:0] t2,
                             input logic [3:0] rd);
    bus.inst_valid     = 1'b1;
    bus.inst_opcode    = 7'($urandom);
    bus.inst_func3     = 3'($urandom);
    bus.inst_func1     = 1'($urandom);
    bus.inst_rs1_valid = v1; bus.inst_rs1_data = d1; bus.inst_rs1_rob = t1;
    bus.inst_rs2_valid = v2; bus.inst_rs2_data = d2; bus.inst_rs2_rob = t2;
    bus.inst_rd_rob    = rd;
    bus.inst_imm       = $urandom;
    bus.inst_pc        = $urandom;
  endtask

  task automatic setCdb(input int ch, input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_valid[ch]                = 1'b1;
    bus.cdb_rob[ch*ROB_W +: ROB_W]   = tag;
    bus.cdb_data[ch*DATA_W +: DATA_W] = data;
  endtask

  // Advance one cycle and return the one-shot inputs to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b0;
    bus.cdb_valid  = '0;
    rollback       = 1'b0;
  endtask

  initial begin
    bus.inst_valid = 1'b0; bus.inst_opcode = '0; bus.inst_func3 = '0; bus.inst_func1 = 1'b0;
    bus.inst_rs1_valid = 1'b0; bus.inst_rs2_valid = 1'b0;
    bus.inst_rs1_data = '0; bus.inst_rs2_data = '0;
    bus.inst_rs1_rob = '0; bus.inst_rs2_rob = '0; bus.inst_rd_rob = '0;
    bus.inst_imm = '0; bus.inst_pc = '0;
    bus.cdb_valid = '0; bus.cdb_rob = '0; bus.cdb_data = '0; bus.exe_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_exe_valid", 160'(bus.exe_valid), 160'(0));
    checkOutput("reset_rs_count", 160'(bus.rs_count), 160'(0));
    checkOutput("reset_rs_full", 160'(bus.rs_full), 160'(0));
    checkOutput("reset_almost_full", 160'(bus.rs_almost_full), 160'(0));
    checkOutput("reset_exe_data1", 160'(bus.exe_data1), 160'(0));
    checkOutput("reset_exe_rob", 160'(bus.exe_rob), 160'(0));
    rst_n = 1'b1;
    rdy = 1'b1;
    bus.exe_ready = 1'b1;
    applyStimulus();

    // A: both operands ready
    setDispatch(1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    applyStimulus();
    repeat (3) applyStimulus();

    // B and C wait on rob 2, broadcast on channel 1
    setDispatch(1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0, 4'd8);
    applyStimulus();
    setDispatch(1'b0, 32'd0, 4'd2, 1'b1, 32'd2, 4'd0, 4'd9);
    applyStimulus();
    setCdb(1, 4'd2, 32'h10);
    applyStimulus();
    repeat (4) applyStimulus();

    // D bypasses rob 6 from channel 0 at dispatch
    setDispatch(1'b0, 32'd0, 4'd6, 1'b1, 32'd3, 4'd0, 4'd10);
    setCdb(0, 4'd6, 32'hAB);
    applyStimulus();
    repeat (3) applyStimulus();

    // Fill under back-pressure, with extra dispatches against a full station
    bus.exe_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      setDispatch(1'b1, 32'(i), 4'd0, 1'b1, 32'(i + 100), 4'd0, 4'(i));
      applyStimulus();
    end
    repeat (3) applyStimulus();
    bus.exe_ready = 1'b1;
    repeat (DEPTH + 4) applyStimulus();

    // Rollback with entries pending and exe_valid high
    bus.exe_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      setDispatch(1'b1, 32'(i + 200), 4'd0, 1'b1, 32'(i), 4'd0, 4'(i));
      applyStimulus();
    end
    rollback = 1'b1;
    applyStimulus();
    bus.exe_ready = 1'b1;
    repeat (5) applyStimulus();

    // rdy low with broadcast and dispatch traffic must not move anything
    setDispatch(1'b0, 32'd0, 4'd4, 1'b0, 32'd0, 4'd5, 4'd1);
    applyStimulus();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setCdb(0, 4'd4, 32'h4444);
      setCdb(1, 4'd5, 32'h5555);
      setDispatch(1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0, 4'd2);
      applyStimulus();
    end
    rdy = 1'b1;
    repeat (2) applyStimulus();
    setCdb(0, 4'd4, 32'h44);
    setCdb(1, 4'd5, 32'h55);
    applyStimulus();
    repeat (3) applyStimulus();

    // Asynchronous reset pulse between edges with entries busy
    bus.exe_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setDispatch(1'b1, 32'(i + 300), 4'd0, 1'b1, 32'(i), 4'd0, 4'(i));
      applyStimulus();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_exe_valid", 160'(bus.exe_valid), 160'(0));
    checkOutput("async_rs_count", 160'(bus.rs_count), 160'(0));
    checkOutput("async_rs_full", 160'(bus.rs_full), 160'(0));
    checkOutput("async_exe_data1", 160'(bus.exe_data1), 160'(0));
    checkOutput("async_exe_pc", 160'(bus.exe_pc), 160'(0));
    #1 rst_n = 1'b1;
    bus.exe_ready = 1'b1;
    applyStimulus();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 15) != 0);
      bus.exe_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        setDispatch(1'($urandom), $urandom, 4'($urandom), 1'($urandom), $urandom,
                    4'($urandom), 4'($urandom));
      for (int ch = 0; ch < CDB_N; ch++)
        if ($urandom_range(0, 2) == 0) setCdb(ch, 4'($urandom), $urandom);
      rollback = ($urandom_range(0, 99) == 0);
      applyStimulus();
    end

    // Drain: broadcast every tag, then wait a bounded time for empty
    rdy = 1'b1;
    bus.exe_ready = 1'b1;
    for (int t = 0; t < 16; t += 2) begin
      setCdb(0, 4'(t), $urandom);
      setCdb(1, 4'(t + 1), $urandom);
      applyStimulus();
    end
    for (int c = 0; c < 200 && (bus.rs_count != 0 || bus.exe_valid); c++) applyStimulus();
    checkOutput("drain_rs_count", 160'(bus.rs_count), 160'(0));
    checkOutput("drain_exe_valid", 160'(bus.exe_valid), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
